// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   // True when rs1 is treated as a signed operand. rs2 is signed for the
   // same ops except MULHSU.
   function automatic logic is_signed_op(input logic [2:0] f3);
      return (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: BITS_PER_CYCLE shift-add multiply
// steps or BITS_PER_CYCLE cascaded restoring-divide steps on magnitudes.
//   multiply: {hi,lo} = {accumulator, multiplier}, shifts right
//   divide:   {hi,lo} = {partial remainder, dividend/quotient}, shifts left
module muldiv_step #(
   parameter int DW  = 64,
   parameter int BPC = 1
) (
   input  logic          i_div,
   input  logic [DW-1:0] i_hi,
   input  logic [DW-1:0] i_lo,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_hi,
   output logic [DW-1:0] o_lo
);

   logic [DW-1:0] hi, lo;
   logic [DW:0]   sh, sum;

   // Cascade BPC single-bit stages; the remainder always stays below the
   // divisor and the shifted accumulator below 2^DW, so DW bits suffice.
   always_comb begin
      hi  = i_hi;
      lo  = i_lo;
      sh  = '0;
      sum = '0;
      for (int k = 0; k < BPC; k++) begin
         if (i_div) begin
            sh = {hi, lo[DW-1]};
            if (sh >= {1'b0, i_b}) begin
               sh = sh - {1'b0, i_b};
               lo = {lo[DW-2:0], 1'b1};
            end else begin
               lo = {lo[DW-2:0], 1'b0};
            end
            hi = sh[DW-1:0];
         end else begin
            sum = {1'b0, hi} + (lo[0] ? {1'b0, i_b} : {(DW+1){1'b0}});
            hi  = sum[DW:1];
            lo  = {sum[0], lo[DW-1:1]};
         end
      end
      o_hi = hi;
      o_lo = lo;
   end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage. Works on
// operand magnitudes, applies signs on the final iteration, and stalls the
// front of the pipeline until the registered result is ready.
module execute_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int BITS_PER_CYCLE = 1,
   parameter int WORD_OPS       = 1
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_start,
   input  logic [2:0]            i_func3,
   input  logic                  i_word,
   input  logic [DATA_WIDTH-1:0] i_src1,
   input  logic [DATA_WIDTH-1:0] i_src2,
   input  logic                  i_flush,
   input  logic                  i_stall_mem,
   output logic                  o_stall_req,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result
);

   localparam int DW   = DATA_WIDTH;
   localparam int W_SH = DW - 32;   // offset of a word operand/result in the full-width datapath
   localparam int CW   = 8;
   localparam logic [CW-1:0] LAST_FULL = CW'(DW / BITS_PER_CYCLE - 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(32 / BITS_PER_CYCLE - 1);
   localparam logic [DW-1:0] MOST_NEG  = {1'b1, {(DW-1){1'b0}}};

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic            word_q, word_d, neg_q, neg_d;
   logic [DW-1:0]   result_q, result_d;
   logic            done_q, done_d, busy_q, busy_d;

   // decode of the incoming instruction
   logic            word_en, is_div, is_rem, a_sgn, b_sgn, neg_a, neg_b;
   logic            b_zero, ovf, special;
   logic [2:0]      f3_eff;
   logic [DW-1:0]   a_ext, b_ext, mag_a, mag_b, a_wres, spec_res;

   // step outputs and final sign fix-up
   logic [DW-1:0]   st_hi, st_lo;
   logic [2*DW-1:0] prod, prod_s;
   logic [DW-1:0]   q_s, r_s, sel_full, fin;
   logic [31:0]     sel_w;

   // Operand conditioning and divide special-case detection for IDLE.
   always_comb begin
      word_en  = (WORD_OPS != 0) && i_word;
      is_div   = i_func3[2];
      is_rem   = i_func3[2] & i_func3[1];
      f3_eff   = (word_en && !is_div) ? OP_MUL : i_func3;
      a_sgn    = is_signed_op(f3_eff);
      b_sgn    = a_sgn && (f3_eff != OP_MULHSU);
      if (word_en) begin
         a_ext = a_sgn ? DW'($signed(i_src1[31:0])) : DW'(i_src1[31:0]);
         b_ext = b_sgn ? DW'($signed(i_src2[31:0])) : DW'(i_src2[31:0]);
      end else begin
         a_ext = i_src1;
         b_ext = i_src2;
      end
      neg_a    = a_sgn & a_ext[DW-1];
      neg_b    = b_sgn & b_ext[DW-1];
      mag_a    = neg_a ? -a_ext : a_ext;
      mag_b    = neg_b ? -b_ext : b_ext;
      b_zero   = word_en ? (i_src2[31:0] == 32'd0) : (i_src2 == '0);
      ovf      = a_sgn && is_div &&
                 (word_en ? ((i_src1[31:0] == 32'h8000_0000) && (&i_src2[31:0]))
                          : ((i_src1 == MOST_NEG) && (&i_src2)));
      special  = is_div && (b_zero || ovf);
      a_wres   = word_en ? DW'($signed(i_src1[31:0])) : i_src1;
      if (b_zero)
         spec_res = is_rem ? a_wres : {DW{1'b1}};
      else
         spec_res = is_rem ? {DW{1'b0}} : a_wres;
   end

   muldiv_step #(
      .DW  (DW),
      .BPC (BITS_PER_CYCLE)
   ) u_step (
      .i_div (op_q[2]),
      .i_hi  (hi_q),
      .i_lo  (lo_q),
      .i_b   (b_q),
      .o_hi  (st_hi),
      .o_lo  (st_lo)
   );

   // Sign-correct and select the result from the last iteration's outputs.
   always_comb begin
      prod   = {st_hi, st_lo};
      prod_s = neg_q ? -prod : prod;
      q_s    = neg_q ? -st_lo : st_lo;
      r_s    = neg_q ? -st_hi : st_hi;
      case (op_q)
         OP_MUL:                       sel_full = prod_s[DW-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: sel_full = prod_s[2*DW-1:DW];
         OP_DIV, OP_DIVU:              sel_full = q_s;
         default:                      sel_full = r_s;
      endcase
      // word multiply leaves the product W_SH bits up in {hi,lo}
      sel_w = op_q[2] ? sel_full[31:0] : prod_s[W_SH +: 32];
      fin   = word_q ? DW'($signed(sel_w)) : sel_full;
   end

   // Next-state logic; flush overrides everything else.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      op_d     = op_q;
      word_d   = word_q;
      neg_d    = neg_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (i_start && !i_flush) begin
               op_d   = f3_eff;
               word_d = word_en;
               neg_d  = is_rem ? neg_a : (neg_a ^ neg_b);
               cnt_d  = '0;
               if (special) begin
                  state_d  = DONE;
                  result_d = spec_res;
               end else begin
                  state_d = CALC;
                  hi_d    = '0;
                  // word dividends start at the top so quotient bits land in [31:0]
                  lo_d    = (is_div && word_en) ? (mag_a << W_SH) : mag_a;
                  b_d     = mag_b;
               end
            end
         end
         CALC: begin
            hi_d  = st_hi;
            lo_d  = st_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == (word_q ? LAST_WORD : LAST_FULL)) begin
               state_d  = DONE;
               result_d = fin;
            end
         end
         DONE: begin
            if (!i_stall_mem) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (i_flush) state_d = IDLE;
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   // State, working registers and registered outputs.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         op_q     <= op_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Stall drops in DONE so the pipeline register captures o_result.
   assign o_stall_req = ~i_arst & (((state_q == IDLE) & i_start & ~i_flush) | (state_q == CALC));
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_result    = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit (DATA_WIDTH=64, BITS_PER_CYCLE=1).
module tb_execute_muldiv_unit;

   logic        i_clk = 1'b0;
   logic        i_arst, i_start, i_word, i_flush, i_stall_mem;
   logic [2:0]  i_func3;
   logic [63:0] i_src1, i_src2;
   logic        o_stall_req, o_busy, o_done;
   logic [63:0] o_result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
      string       nm;
   } vec_t;

   vec_t vt[$];

   execute_muldiv_unit #(
      .DATA_WIDTH     (64),
      .BITS_PER_CYCLE (1),
      .WORD_OPS       (1)
   ) dut (
      .i_clk       (i_clk),
      .i_arst      (i_arst),
      .i_start     (i_start),
      .i_func3     (i_func3),
      .i_word      (i_word),
      .i_src1      (i_src1),
      .i_src2      (i_src2),
      .i_flush     (i_flush),
      .i_stall_mem (i_stall_mem),
      .o_stall_req (o_stall_req),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Issue one op (start held until DONE is left), check latency, result,
   // stall profile and the return to IDLE. Called at posedge+1.
   task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input string nm);
      int cyc;
      bit seen, stall_ok;
      i_func3 = f3; i_word = w; i_src1 = a; i_src2 = b; i_start = 1'b1;
      #1;
      stall_ok = (o_stall_req === 1'b1);
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         if (o_done === 1'b1) seen = 1;
         else if (o_stall_req !== 1'b1) stall_ok = 0;
      end
      check({nm, " done"}, 64'(seen), 64'd1);
      check({nm, " latency"}, 64'(cyc), 64'(lat));
      check({nm, " result"}, o_result, exp);
      check({nm, " stall in DONE"}, 64'(o_stall_req), 64'd0);
      check({nm, " stall while busy"}, 64'(stall_ok), 64'd1);
      tick();
      i_start = 1'b0;
      #1;
      check({nm, " idle after"}, {62'd0, o_busy, o_done}, 64'd0);
   endtask

   initial begin
      int cyc;
      bit seen;

      vt.push_back('{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "MUL 7x-3"});
      vt.push_back('{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "MULHU ones"});
      vt.push_back('{3'd1, 1'b0, '1, '1, 64'd0, 65, "MULH ones"});
      vt.push_back('{3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "MULHSU -1x2"});
      vt.push_back('{3'd0, 1'b0, 64'd0, 64'd5, 64'd0, 65, "MUL 0x5"});
      vt.push_back('{3'd4, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "DIV by 0"});
      vt.push_back('{3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 1, "REM by 0"});
      vt.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "DIV ovf"});
      vt.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "REM ovf"});
      vt.push_back('{3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "DIVW -7/2"});
      vt.push_back('{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "REMW -7/2"});
      vt.push_back('{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, "DIVU 100/7"});
      vt.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, "REM -100/7"});
      vt.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "DIV -7/2"});
      vt.push_back('{3'd0, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'd0, 33, "MULW wrap"});
      vt.push_back('{3'd0, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33, "MULW -1x3"});
      vt.push_back('{3'd3, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "MULHU.W as MULW"});
      vt.push_back('{3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, "DIVUW"});
      vt.push_back('{3'd4, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "DIVW by 0"});
      vt.push_back('{3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, "REMUW by 0"});
      vt.push_back('{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "DIVW ovf"});

      i_arst = 1'b1; i_start = 1'b0; i_word = 1'b0; i_flush = 1'b0; i_stall_mem = 1'b0;
      i_func3 = 3'd0; i_src1 = '0; i_src2 = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset outputs", {61'd0, o_stall_req, o_busy, o_done}, 64'd0);
      check("reset result", o_result, 64'd0);
      i_arst = 1'b0;
      tick();

      foreach (vt[i]) run_op(vt[i].f3, vt[i].w, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, vt[i].nm);

      // flush on CALC cycle 10 kills the op without a result
      i_func3 = 3'd5; i_word = 1'b0; i_src1 = 64'd1000; i_src2 = 64'd3; i_start = 1'b1;
      repeat (10) tick();
      check("flush pre busy", 64'(o_busy), 64'd1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0; i_start = 1'b0;
      #1;
      check("flush to idle", {61'd0, o_stall_req, o_busy, o_done}, 64'd0);
      seen = 0;
      repeat (80) begin
         tick();
         if (o_done === 1'b1) seen = 1;
      end
      check("flush no done", 64'(seen), 64'd0);
      run_op(3'd5, 1'b0, 64'd9, 64'd2, 64'd4, 65, "DIVU 9/2 after flush");

      // memory stall holds DONE; i_start stays high and is ignored
      i_stall_mem = 1'b1;
      i_func3 = 3'd0; i_word = 1'b1; i_src1 = 64'd3; i_src2 = 64'd5; i_start = 1'b1;
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         tick();
         cyc++;
         if (o_done === 1'b1) seen = 1;
      end
      check("stall latency", 64'(cyc), 64'd33);
      for (int k = 0; k < 3; k++) begin
         check("stall hold done", {62'd0, o_done, o_stall_req}, 64'd2);
         check("stall hold result", o_result, 64'd15);
         tick();
      end
      i_stall_mem = 1'b0;
      #1;
      check("stall release done", 64'(o_done), 64'd1);
      tick();
      i_start = 1'b0;
      #1;
      check("stall release idle", {62'd0, o_busy, o_done}, 64'd0);
      check("result kept", o_result, 64'd15);

      // asynchronous reset mid-CALC
      i_func3 = 3'd0; i_word = 1'b0; i_src1 = 64'd11; i_src2 = 64'd13; i_start = 1'b1;
      repeat (20) tick();
      check("pre-reset busy", 64'(o_busy), 64'd1);
      i_arst = 1'b1;
      #1;
      check("async reset flags", {61'd0, o_stall_req, o_busy, o_done}, 64'd0);
      check("async reset result", o_result, 64'd0);
      i_start = 1'b0;
      tick();
      i_arst = 1'b0;
      repeat (3) tick();
      check("post-reset idle", {61'd0, o_stall_req, o_busy, o_done}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
